run_dump_controller: RTL

Parametrised run/halt supervisor and state-dump engine for the single-cycle datapath harness. It watches PC and instruction every cycle, streams a buffered PC trace, and detects halt (programmable halt instruction) or cycle timeout. After halt or timeout it freezes the machine and streams the register file and a memory window through one valid/ready dump port. It generalises the fixed testbench dump to synthesizable, configurable depth, window and timeout, and adds backpressure and overflow reporting.

---
 rtl/run_dump_controller.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/run_dump_controller.sv
// run_dump_controller: run/halt supervisor and state-dump engine.
// While the machine runs, the PC of every cycle goes into a small trace FIFO,
// and the head of that FIFO is offered on the dump port. A halt instruction or
// a cycle timeout freezes the machine. The engine then drains the trace, walks
// the register file and streams a memory window through the same valid/ready
// port.
module run_dump_controller #(
   parameter int unsigned NUM_REGS    = 32,
   parameter logic [31:0] MEM_BASE    = 32'h00004000,
   parameter int unsigned MEM_LEN     = 4,
   parameter int unsigned MAX_CYCLES  = 64,
   parameter int unsigned TRACE_DEPTH = 8,
   parameter logic [31:0] HALT_INST   = 32'h00000000,
   localparam int unsigned REG_AW     = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       pc,
   input  logic [31:0]       inst,
   output logic              stop,
   output logic [REG_AW-1:0] reg_rd_addr,
   input  logic [31:0]       reg_rd_data,
   output logic [31:0]       mem_rd_addr,
   input  logic [7:0]        mem_rd_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [1:0]        dump_kind,
   output logic [31:0]       dump_data,
   output logic              halted,
   output logic              timed_out,
   output logic              trace_overflow,
   output logic              done,
   output logic [31:0]       cycle_count
);

   localparam int unsigned   PTR_W      = $clog2(TRACE_DEPTH);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(TRACE_DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [31:0]   CYCLE_LAST = 32'(MAX_CYCLES - 1);
   localparam logic [31:0]   REG_LAST   = 32'(NUM_REGS - 1);
   localparam logic [31:0]   MEM_LAST   = (MEM_LEN == 0) ? 32'd0 : 32'(MEM_LEN - 1);

   typedef enum logic [2:0] {
      ST_RUN,
      ST_DRAIN,
      ST_REGS,
      ST_MEM,
      ST_DONE
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [31:0]       fifo_mem [TRACE_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    fifo_count;

   logic [31:0]       idx_q;
   logic [31:0]       cycle_q;
   logic              halted_q;
   logic              timed_out_q;
   logic              overflow_q;
   logic              stop_q;

   logic              fifo_empty;
   logic              fifo_full;
   logic              handshake;
   logic              pop;
   logic              push;
   logic              drop;
   logic              is_halt;
   logic              is_timeout;

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == CNT_FULL);
   assign handshake  = dump_valid && dump_ready;
   assign pop        = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && handshake;
   assign push       = (state_q == ST_RUN) && (!fifo_full || pop);
   assign drop       = (state_q == ST_RUN) && fifo_full && !pop;
   assign is_halt    = (inst == HALT_INST);
   assign is_timeout = (cycle_q == CYCLE_LAST);

   assign stop           = stop_q;
   assign halted         = halted_q;
   assign timed_out      = timed_out_q;
   assign trace_overflow = overflow_q;
   assign cycle_count    = cycle_q;
   assign done           = (state_q == ST_DONE);

   // Phase register: RUN, then the dump phases, then DONE until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Phase sequencing: leave RUN on halt/timeout; leave each dump phase when its last entry is taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (is_halt || is_timeout) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty || (pop && (fifo_count == CNT_ONE))) begin
               state_d = ST_REGS;
            end
         end
         ST_REGS: begin
            if (handshake && (idx_q == REG_LAST)) begin
               state_d = (MEM_LEN == 0) ? ST_DONE : ST_MEM;
            end
         end
         ST_MEM: begin
            if (handshake && (idx_q == MEM_LAST)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Dump port mux: trace head while tracing, register/memory read data in the dump phases.
   always_comb begin
      dump_valid  = 1'b0;
      dump_kind   = 2'd0;
      dump_data   = 32'd0;
      mem_rd_addr = 32'd0;
      reg_rd_addr = idx_q[REG_AW-1:0];
      case (state_q)
         ST_RUN, ST_DRAIN: begin
            dump_valid = !fifo_empty;
            dump_data  = fifo_empty ? 32'd0 : fifo_mem[rd_ptr];
         end
         ST_REGS: begin
            dump_valid = 1'b1;
            dump_kind  = 2'd1;
            dump_data  = reg_rd_data;
         end
         ST_MEM: begin
            dump_valid  = 1'b1;
            dump_kind   = 2'd2;
            mem_rd_addr = MEM_BASE + idx_q;
            dump_data   = {24'd0, mem_rd_data};
         end
         default: begin
            dump_valid = 1'b0;
         end
      endcase
   end

   // Trace storage: plain memory, only written on an accepted push.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= pc;
      end
   end

   // Trace pointers and occupancy; a push into a full FIFO only succeeds when the head leaves in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_ONE;
            2'b01:   fifo_count <= fifo_count - CNT_ONE;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Dump index: walks registers, restarts at zero, then walks the memory window; advances only on handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q <= 32'd0;
      end else if (handshake) begin
         if (state_q == ST_REGS) begin
            idx_q <= (idx_q == REG_LAST) ? 32'd0 : idx_q + 32'd1;
         end else if (state_q == ST_MEM) begin
            idx_q <= idx_q + 32'd1;
         end
      end
   end

   // Run supervision: halt beats timeout, the stopping cycle is not counted, and all flags are sticky.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_q     <= 32'd0;
         halted_q    <= 1'b0;
         timed_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         stop_q      <= 1'b0;
      end else begin
         if (state_q == ST_RUN) begin
            if (is_halt) begin
               halted_q <= 1'b1;
               stop_q   <= 1'b1;
            end else if (is_timeout) begin
               timed_out_q <= 1'b1;
               stop_q      <= 1'b1;
            end else begin
               cycle_q <= cycle_q + 32'd1;
            end
         end
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

endmodule
